trace_unloader: RTL and testbench

Drains captured words from the trace buffer and serialises them onto a single-clock, JTAG-style shift interface for off-chip readout. Sits between the trace buffer's read port (`rd`/`dout`) and the debug TAP data register logic: on a debug request it issues one read pulse per word, captures the returned word and shifts it out LSB-first under control of the TAP's shift strobes.

---
 rtl/trace_dfd_pkg.sv | 28 ++
 rtl/trace_unloader_if.sv | 30 +++
 rtl/trace_shift_reg.sv | 56 +++++
 rtl/trace_unloader.sv | 115 +++++++++++
 tb/tb_trace_unloader.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/trace_dfd_pkg.sv
// Shared trace unloader types, default sizes and parity helper.
// TRACE_UNLOAD_PARITY_EN appends one even-parity bit to every shifted word.
package trace_dfd_pkg;

   localparam int unsigned FPAY_DEF  = 32;
   localparam int unsigned TB_AW_DEF = 9;

`ifdef TRACE_UNLOAD_PARITY_EN
   localparam int unsigned PARITY_BITS = 1;
`else
   localparam int unsigned PARITY_BITS = 0;
`endif

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      FETCH = 3'd1,
      WAIT  = 3'd2,
      LOAD  = 3'd3,
      SHIFT = 3'd4,
      DONE  = 3'd5
   } unload_state_t;

   // Even parity over a zero-extended word; zero padding does not change the XOR.
   function automatic logic even_parity(input logic [63:0] w);
      return ^w;
   endfunction

endpackage

// File: rtl/trace_unloader_if.sv
// Debug-controller / trace-buffer / TAP signal bundle for the trace unloader.
interface trace_unloader_if
   import trace_dfd_pkg::*;
#(
   parameter int unsigned Fpay  = FPAY_DEF,
   parameter int unsigned TB_AW = TB_AW_DEF
);
   logic             dbg_req;
   logic             dbg_abort;
   logic [TB_AW-1:0] req_count;
   logic [TB_AW-1:0] tb_level;
   logic             tb_rd;
   logic [Fpay-1:0]  tb_dout;
   logic             shift_en;
   logic             tdo;
   logic             word_rdy;
   logic             busy;
   logic             done;
   logic [TB_AW-1:0] words_sent;

   modport master (
      output dbg_req, dbg_abort, req_count, tb_level, tb_dout, shift_en,
      input  tb_rd, tdo, word_rdy, busy, done, words_sent
   );

   modport slave (
      input  dbg_req, dbg_abort, req_count, tb_level, tb_dout, shift_en,
      output tb_rd, tdo, word_rdy, busy, done, words_sent
   );
endinterface

// File: rtl/trace_shift_reg.sv
// Parallel-load right-shift register with bit counter for trace word serialisation.
// TRACE_UNLOAD_PARITY_EN loads an even-parity bit above the data bits.
module trace_shift_reg
   import trace_dfd_pkg::*;
#(
   parameter int unsigned Fpay = FPAY_DEF
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            load_i,
   input  logic            shift_i,
   input  logic [Fpay-1:0] data_i,
   output logic            nxt_bit_c,
   output logic            last_bit_o
);
   localparam int unsigned WordLen = Fpay + PARITY_BITS;
   localparam int unsigned CntW    = $clog2(WordLen + 1);

   logic [WordLen-1:0] sreg_q, sreg_d;
   logic [CntW-1:0]    cnt_q, cnt_d;
   logic               last_q, last_d;

   always_comb begin
      sreg_d = sreg_q;
      cnt_d  = cnt_q;
      if (load_i) begin
`ifdef TRACE_UNLOAD_PARITY_EN
         sreg_d = {even_parity(64'(data_i)), data_i};
`else
         sreg_d = data_i;
`endif
         cnt_d  = '0;
      end else if (shift_i) begin
         sreg_d = sreg_q >> 1;
         cnt_d  = cnt_q + CntW'(1);
      end
      // last_bit flags that the bit currently presented is the final one of the word
      last_d    = (cnt_d == CntW'(WordLen - 1));
      nxt_bit_c = sreg_d[0];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sreg_q <= '0;
         cnt_q  <= '0;
         last_q <= 1'b0;
      end else begin
         sreg_q <= sreg_d;
         cnt_q  <= cnt_d;
         last_q <= last_d;
      end
   end

   assign last_bit_o = last_q;

endmodule

// File: rtl/trace_unloader.sv
// Drains trace buffer words and shifts them LSB-first onto a TAP-style serial output.
// TRACE_UNLOAD_PARITY_EN (via trace_dfd_pkg) adds an even-parity bit per word.
module trace_unloader
   import trace_dfd_pkg::*;
#(
   parameter int unsigned Fpay  = FPAY_DEF,
   parameter int unsigned TB_AW = TB_AW_DEF
) (
   input  logic             clk,
   input  logic             reset,
   trace_unloader_if.slave  bus
);
   unload_state_t    state_q, state_d;
   logic [TB_AW-1:0] n_q, n_d;
   logic [TB_AW-1:0] words_q, words_d;
   logic             abort_q, abort_d;
   logic             tb_rd_q, tb_rd_d;
   logic             tdo_q, tdo_d;
   logic             word_rdy_q, word_rdy_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             load_c, shift_c;
   logic             nxt_bit_c, last_bit;
   logic             abort_pending_c;

   trace_shift_reg #(.Fpay(Fpay)) u_shift (
      .clk        (clk),
      .rst_n      (reset),
      .load_i     (load_c),
      .shift_i    (shift_c),
      .data_i     (bus.tb_dout),
      .nxt_bit_c  (nxt_bit_c),
      .last_bit_o (last_bit)
   );

   // Next-state, counters and registered-output decode
   always_comb begin
      state_d         = state_q;
      n_d             = n_q;
      words_d         = words_q;
      abort_d         = abort_q;
      load_c          = 1'b0;
      shift_c         = 1'b0;
      abort_pending_c = abort_q | bus.dbg_abort;

      case (state_q)
         IDLE: begin
            if (bus.dbg_req) begin
               n_d     = (bus.req_count < bus.tb_level) ? bus.req_count : bus.tb_level;
               words_d = '0;
               state_d = (n_d == '0) ? DONE : FETCH;
            end
         end
         FETCH: state_d = WAIT;
         WAIT:  state_d = LOAD;
         LOAD: begin
            load_c  = 1'b1;
            state_d = SHIFT;
         end
         SHIFT: begin
            if (bus.shift_en) begin
               shift_c = 1'b1;
               if (last_bit) begin
                  words_d = words_q + TB_AW'(1);
                  state_d = ((words_q + TB_AW'(1)) == n_q || abort_pending_c) ? DONE : FETCH;
               end
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      // Abort is sticky for the unload and forgotten once back in IDLE
      if (state_q != IDLE && bus.dbg_abort) abort_d = 1'b1;
      if (state_d == IDLE)                  abort_d = 1'b0;

      tb_rd_d    = (state_d == FETCH);
      word_rdy_d = (state_d == SHIFT);
      busy_d     = (state_d != IDLE);
      done_d     = (state_d == DONE);
      tdo_d      = (state_d == SHIFT) & nxt_bit_c;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         n_q        <= '0;
         words_q    <= '0;
         abort_q    <= 1'b0;
         tb_rd_q    <= 1'b0;
         tdo_q      <= 1'b0;
         word_rdy_q <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         n_q        <= n_d;
         words_q    <= words_d;
         abort_q    <= abort_d;
         tb_rd_q    <= tb_rd_d;
         tdo_q      <= tdo_d;
         word_rdy_q <= word_rdy_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

   assign bus.tb_rd      = tb_rd_q;
   assign bus.tdo        = tdo_q;
   assign bus.word_rdy   = word_rdy_q;
   assign bus.busy       = busy_q;
   assign bus.done       = done_q;
   assign bus.words_sent = words_q;

endmodule

// File: tb/tb_trace_unloader.sv
// Directed bench for trace_unloader: vector table plus latency, empty-request and reset sequences.
module tb_trace_unloader;
`ifdef TRACE_UNLOAD_PARITY_EN
   localparam int WL = 33;
`else
   localparam int WL = 32;
`endif

   logic clk   = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   trace_unloader_if #(.Fpay(32), .TB_AW(9)) bus ();

   trace_unloader #(.Fpay(32), .TB_AW(9)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // Trace buffer model: registered read, pointer never rewinds
   logic [31:0] mem [64];
   logic [5:0]  rd_ptr = '0;
   always @(posedge clk) begin
      if (bus.tb_rd) begin
         bus.tb_dout <= mem[rd_ptr];
         rd_ptr      <= rd_ptr + 6'd1;
      end
   end

   int   rd_cnt = 0, done_cnt = 0, tdo_leak = 0;
   logic got_bits [$];
   always @(negedge clk) begin
      if (bus.tb_rd) rd_cnt++;
      if (bus.done) done_cnt++;
      if (bus.word_rdy && bus.shift_en) got_bits.push_back(bus.tdo);
      if (!bus.word_rdy && bus.tdo) tdo_leak++;
   end

   int n_tests = 0, n_fail = 0;
   int cyc = 0;
   int shift_mode = 0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
      cyc++;
      bus.shift_en = (shift_mode == 0) ? 1'b1 : cyc[0];
   endtask

   task automatic run_tx(input string name, input logic [8:0] req, input logic [8:0] lvl,
                         input int mode, input int abort_word,
                         input int exp_reads, input int exp_words);
      int   rd0, dn0, bits0, guard, errs, bi;
      logic [5:0]  base;
      logic [31:0] word;
      logic        ebit;
      bit          aborted;
      rd0 = rd_cnt; dn0 = done_cnt; bits0 = got_bits.size(); base = rd_ptr;
      aborted = 1'b0;
      shift_mode = mode;
      bus.req_count = req; bus.tb_level = lvl; bus.dbg_req = 1'b1;
      tick();
      bus.dbg_req = 1'b0;
      guard = 0;
      while (bus.busy && guard < 4000) begin
         if (abort_word >= 0 && !aborted && bus.word_rdy && int'(bus.words_sent) == abort_word) begin
            bus.dbg_abort = 1'b1;
            bus.dbg_req   = 1'b1;
            tick();
            bus.dbg_abort = 1'b0;
            bus.dbg_req   = 1'b0;
            aborted = 1'b1;
         end else begin
            tick();
         end
         guard++;
      end
      if (guard >= 4000) begin
         n_tests++; n_fail++;
         $display("FAIL %s timeout: busy still %0b after %0d cycles", name, bus.busy, guard);
      end
      tick();
      check({name, " reads"}, 32'(rd_cnt - rd0), 32'(exp_reads));
      check({name, " words_sent"}, 32'(bus.words_sent), 32'(exp_words));
      check({name, " done_pulses"}, 32'(done_cnt - dn0), 32'd1);
      check({name, " nbits"}, 32'(got_bits.size() - bits0), 32'(exp_words * WL));
      errs = 0; bi = bits0;
      for (int w = 0; w < exp_words; w++) begin
         word = mem[6'(int'(base) + w)];
         for (int b = 0; b < WL; b++) begin
            ebit = (b < 32) ? word[b] : ^word;
            if (bi >= got_bits.size() || got_bits[bi] !== ebit) errs++;
            bi++;
         end
      end
      check({name, " stream_errs"}, 32'(errs), 32'd0);
   endtask

   typedef struct {
      string      name;
      logic [8:0] req;
      logic [8:0] lvl;
      int         mode;
      int         abort_word;
      int         exp_reads;
      int         exp_words;
   } vec_t;

   vec_t vecs [7];

   initial begin
      int rd0, base_i;
      logic [31:0] w0;

      for (int i = 0; i < 64; i++) mem[i] = 32'h1357_9BDF ^ (32'(i) * 32'h0101_0111);
      mem[0] = 32'hA5A5_0001;
      mem[1] = 32'h0000_0002;
      mem[2] = 32'h0000_0007;
      mem[3] = 32'h0000_0003;

      vecs[0] = '{"req2_lvl5",   9'd2, 9'd5, 0, -1, 2, 2};
      vecs[1] = '{"req8_lvl3",   9'd8, 9'd3, 0, -1, 3, 3};
      vecs[2] = '{"req0",        9'd0, 9'd5, 0, -1, 0, 0};
      vecs[3] = '{"lvl0",        9'd4, 9'd0, 0, -1, 0, 0};
      vecs[4] = '{"req1_lvl1",   9'd1, 9'd1, 1, -1, 1, 1};
      vecs[5] = '{"abort_w1",    9'd4, 9'd4, 1,  1, 2, 2};
      vecs[6] = '{"req5_toggle", 9'd5, 9'd5, 1, -1, 5, 5};

      bus.dbg_req = 1'b0; bus.dbg_abort = 1'b0; bus.req_count = '0;
      bus.tb_level = '0; bus.shift_en = 1'b0; bus.tb_dout = '0;

      tick(); tick();
      check("rst tb_rd", 32'(bus.tb_rd), 32'd0);
      check("rst tdo", 32'(bus.tdo), 32'd0);
      check("rst word_rdy", 32'(bus.word_rdy), 32'd0);
      check("rst busy", 32'(bus.busy), 32'd0);
      check("rst done", 32'(bus.done), 32'd0);
      check("rst words_sent", 32'(bus.words_sent), 32'd0);
      reset = 1'b1;
      tick();

      for (int v = 0; v < 7; v++)
         run_tx(vecs[v].name, vecs[v].req, vecs[v].lvl, vecs[v].mode,
                vecs[v].abort_word, vecs[v].exp_reads, vecs[v].exp_words);

      // Empty request: DONE directly after the request cycle
      rd0 = rd_cnt;
      bus.req_count = 9'd0; bus.tb_level = 9'd3; bus.dbg_req = 1'b1;
      tick();
      bus.dbg_req = 1'b0;
      check("empty c1 done", 32'(bus.done), 32'd1);
      check("empty c1 busy", 32'(bus.busy), 32'd1);
      tick();
      check("empty c2 done", 32'(bus.done), 32'd0);
      check("empty c2 busy", 32'(bus.busy), 32'd0);
      check("empty reads", 32'(rd_cnt - rd0), 32'd0);

      // First-bit latency
      shift_mode = 0;
      base_i = int'(rd_ptr);
      w0 = mem[6'(base_i)];
      bus.req_count = 9'd1; bus.tb_level = 9'd1; bus.dbg_req = 1'b1;
      tick();
      bus.dbg_req = 1'b0;
      check("lat c1 tb_rd", 32'(bus.tb_rd), 32'd1);
      check("lat c1 busy", 32'(bus.busy), 32'd1);
      tick();
      check("lat c2 tb_rd", 32'(bus.tb_rd), 32'd0);
      tick();
      check("lat c3 word_rdy", 32'(bus.word_rdy), 32'd0);
      tick();
      check("lat c4 word_rdy", 32'(bus.word_rdy), 32'd1);
      check("lat c4 tdo", 32'(bus.tdo), 32'(w0[0]));
      for (int i = 0; i < WL + 4; i++) tick();
      check("lat words_sent", 32'(bus.words_sent), 32'd1);
      check("lat busy end", 32'(bus.busy), 32'd0);

      // Reset in the middle of word 1 of 3
      shift_mode = 0;
      bus.req_count = 9'd3; bus.tb_level = 9'd3; bus.dbg_req = 1'b1;
      tick();
      bus.dbg_req = 1'b0;
      for (int g = 0; g < 300; g++) begin
         if (bus.word_rdy && bus.words_sent == 9'd1) break;
         tick();
      end
      check("mid reached word1", 32'(bus.word_rdy && bus.words_sent == 9'd1), 32'd1);
      tick(); tick(); tick();
      reset = 1'b0;
      #1;
      check("mid rst tb_rd", 32'(bus.tb_rd), 32'd0);
      check("mid rst tdo", 32'(bus.tdo), 32'd0);
      check("mid rst word_rdy", 32'(bus.word_rdy), 32'd0);
      check("mid rst busy", 32'(bus.busy), 32'd0);
      check("mid rst words_sent", 32'(bus.words_sent), 32'd0);
      rd0 = rd_cnt;
      tick(); tick(); tick();
      reset = 1'b1;
      for (int i = 0; i < 10; i++) tick();
      check("mid no reads", 32'(rd_cnt - rd0), 32'd0);
      check("mid still idle", 32'(bus.busy), 32'd0);
      run_tx("after_rst", 9'd1, 9'd7, 0, -1, 1, 1);

      check("tdo outside shift", 32'(tdo_leak), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
